// File: rtl/sram_ctrl_param_if.sv
// rtl/sram_ctrl_param_if.sv - MEM-stage side request/response bundle of the SRAM controller
interface sram_ctrl_param_if #(
   parameter int DATA_W = 32
) ();
   logic                  wr_en;
   logic                  rd_en;
   logic [31:0]           addr;
   logic [DATA_W-1:0]     wr_data;
   logic [DATA_W/8-1:0]   byte_en;
   logic [DATA_W-1:0]     rd_data;
   logic                  rd_valid;
   logic                  ready;

   modport master (
      output wr_en, rd_en, addr, wr_data, byte_en,
      input  rd_data, rd_valid, ready
   );

   modport slave (
      input  wr_en, rd_en, addr, wr_data, byte_en,
      output rd_data, rd_valid, ready
   );
endinterface

// File: rtl/sram_ctrl_param.sv
// rtl/sram_ctrl_param.sv - splits DATA_W loads/stores into 16-bit beats on an async SRAM
module sram_ctrl_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 18,
   parameter int WAIT_CYC = 1
) (
   input  logic                clk,
   input  logic                rst,
   sram_ctrl_param_if.slave    bus,
   inout  wire  [15:0]         SRAM_DQ,
   output logic [ADDR_W-1:0]   SRAM_ADDR,
   output logic                SRAM_UB_N,
   output logic                SRAM_LB_N,
   output logic                SRAM_WE_N,
   output logic                SRAM_CE_N,
   output logic                SRAM_OE_N
);
   localparam int BEATS = DATA_W / 16;
   localparam int LB    = $clog2(BEATS);
   localparam int BCW   = (LB < 1) ? 1 : LB;

   typedef enum logic [1:0] {IDLE, WR_BEAT, RD_BEAT, DONE} state_t;

   state_t                state_q, state_d;
   logic [BCW-1:0]        bc_q, bc_d;
   logic [3:0]            wc_q, wc_d;
   logic [ADDR_W-1:0]     haddr_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [DATA_W/8-1:0]   be_q;
   logic [DATA_W-1:0]     asm_q, asm_d;
   logic [DATA_W-1:0]     rd_data_q;
   logic                  rd_valid_q;
   logic                  beat_end, last_beat, busy, rd_done;
   logic [15:0]           wr_hw;
   logic                  be_lo, be_hi;
   logic [ADDR_W-1:0]     beat_addr;
   logic                  unused_addr;

   assign unused_addr = ^{bus.addr[31:ADDR_W+1], bus.addr[0]};

   assign busy      = (state_q == WR_BEAT) || (state_q == RD_BEAT);
   assign beat_end  = busy && (wc_q == 4'(WAIT_CYC));
   assign last_beat = (bc_q == BCW'(BEATS - 1));

   always_comb begin
      state_d = state_q;
      bc_d    = bc_q;
      wc_d    = wc_q;
      case (state_q)
         IDLE: begin
            bc_d = '0;
            wc_d = '0;
            if (bus.wr_en)      state_d = WR_BEAT;
            else if (bus.rd_en) state_d = RD_BEAT;
         end
         WR_BEAT, RD_BEAT: begin
            if (beat_end) begin
               wc_d = '0;
               bc_d = bc_q + BCW'(1);
               if (last_beat) state_d = DONE;
            end else begin
               wc_d = wc_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rd_done = (state_q == RD_BEAT) && (state_d == DONE);

   // Final beat lands in the assembly and in rd_data on the same edge.
   always_comb begin
      asm_d = asm_q;
      if ((state_q == RD_BEAT) && beat_end) begin
         for (int b = 0; b < BEATS; b++) begin
            if (bc_q == BCW'(b)) asm_d[16*b +: 16] = SRAM_DQ;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         bc_q       <= '0;
         wc_q       <= '0;
         haddr_q    <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         asm_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bc_q       <= bc_d;
         wc_q       <= wc_d;
         asm_q      <= asm_d;
         rd_valid_q <= rd_done;
         if (rd_done) rd_data_q <= asm_d;
         if ((state_q == IDLE) && (state_d != IDLE)) begin
            haddr_q <= bus.addr[ADDR_W:1];
            wdata_q <= bus.wr_data;
            be_q    <= bus.byte_en;
         end
      end
   end

   generate
      if (BEATS > 1) begin : g_multi
         assign beat_addr = {haddr_q[ADDR_W-1:LB], bc_q};
      end else begin : g_single
         assign beat_addr = haddr_q;
      end
   endgenerate

   always_comb begin
      wr_hw = '0;
      be_lo = 1'b0;
      be_hi = 1'b0;
      for (int b = 0; b < BEATS; b++) begin
         if (bc_q == BCW'(b)) begin
            wr_hw = wdata_q[16*b +: 16];
            be_lo = be_q[2*b];
            be_hi = be_q[2*b+1];
         end
      end
   end

   always_comb begin
      SRAM_ADDR = '0;
      SRAM_CE_N = 1'b1;
      SRAM_OE_N = 1'b1;
      SRAM_WE_N = 1'b1;
      SRAM_UB_N = 1'b1;
      SRAM_LB_N = 1'b1;
      if (state_q == WR_BEAT) begin
         SRAM_ADDR = beat_addr;
         SRAM_CE_N = 1'b0;
         SRAM_WE_N = 1'b0;
         SRAM_LB_N = ~be_lo;
         SRAM_UB_N = ~be_hi;
      end else if (state_q == RD_BEAT) begin
         SRAM_ADDR = beat_addr;
         SRAM_CE_N = 1'b0;
         SRAM_OE_N = 1'b0;
         SRAM_LB_N = 1'b0;
         SRAM_UB_N = 1'b0;
      end
   end

   assign SRAM_DQ      = (state_q == WR_BEAT) ? wr_hw : 16'hzzzz;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.ready    = (state_d == IDLE);
endmodule

// File: tb/tb_sram_ctrl_param.sv
// tb/tb_sram_ctrl_param.sv - directed bench for sram_ctrl_param with behavioural SRAM models
module tb_sram_ctrl_param;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // 32-bit, WAIT_CYC=1 instance
   sram_ctrl_param_if #(.DATA_W(32)) ifa ();
   wire  [15:0] dq_a;
   logic [17:0] addr_a;
   logic        ub_a, lb_a, we_a, ce_a, oe_a;
   logic [15:0] mem_a [0:255];

   sram_ctrl_param #(.DATA_W(32), .ADDR_W(18), .WAIT_CYC(1)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa), .SRAM_DQ(dq_a), .SRAM_ADDR(addr_a),
      .SRAM_UB_N(ub_a), .SRAM_LB_N(lb_a), .SRAM_WE_N(we_a), .SRAM_CE_N(ce_a), .SRAM_OE_N(oe_a)
   );

   assign dq_a = (!ce_a && !oe_a) ? mem_a[addr_a[7:0]] : 16'hzzzz;
   always @(posedge clk) begin
      if (!ce_a && !we_a) begin
         if (!lb_a) mem_a[addr_a[7:0]][7:0]  <= dq_a[7:0];
         if (!ub_a) mem_a[addr_a[7:0]][15:8] <= dq_a[15:8];
      end
   end

   // 64-bit, WAIT_CYC=0 instance
   sram_ctrl_param_if #(.DATA_W(64)) ifb ();
   wire  [15:0] dq_b;
   logic [17:0] addr_b;
   logic        ub_b, lb_b, we_b, ce_b, oe_b;
   logic [15:0] mem_b [0:255];

   sram_ctrl_param #(.DATA_W(64), .ADDR_W(18), .WAIT_CYC(0)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb), .SRAM_DQ(dq_b), .SRAM_ADDR(addr_b),
      .SRAM_UB_N(ub_b), .SRAM_LB_N(lb_b), .SRAM_WE_N(we_b), .SRAM_CE_N(ce_b), .SRAM_OE_N(oe_b)
   );

   assign dq_b = (!ce_b && !oe_b) ? mem_b[addr_b[7:0]] : 16'hzzzz;
   always @(posedge clk) begin
      if (!ce_b && !we_b) begin
         if (!lb_b) mem_b[addr_b[7:0]][7:0]  <= dq_b[7:0];
         if (!ub_b) mem_b[addr_b[7:0]][15:8] <= dq_b[15:8];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int pulses;
      int we_low;
      ifa.wr_en = 0; ifa.rd_en = 0; ifa.addr = 0; ifa.wr_data = 0; ifa.byte_en = 0;
      ifb.wr_en = 0; ifb.rd_en = 0; ifb.addr = 0; ifb.wr_data = 0; ifb.byte_en = 0;
      step(); step();

      // reset state
      chk("rst_rd_data", ifa.rd_data, 0);
      chk("rst_rd_valid", ifa.rd_valid, 0);
      chk("rst_addr", addr_a, 0);
      chk("rst_strobes", {we_a, ce_a, oe_a, ub_a, lb_a}, 5'b11111);
      chk("rst_ready", ifa.ready, 1);
      chk("rst_rd_data_b", ifb.rd_data, 0);
      rst = 1'b0;
      step();
      chk("idle_ready", ifa.ready, 1);

      // write 0xDEADBEEF @0x40, all bytes
      ifa.wr_en = 1; ifa.addr = 32'h40; ifa.wr_data = 32'hDEADBEEF; ifa.byte_en = 4'hF;
      #1 chk("wr_ready_same_cycle", ifa.ready, 0);
      step(); ifa.wr_en = 0;
      chk("wr_c1_addr", addr_a, 18'h20);
      chk("wr_c1_dq", dq_a, 16'hBEEF);
      chk("wr_c1_we_ce", {we_a, ce_a}, 2'b00);
      chk("wr_c1_ready", ifa.ready, 0);
      step();
      chk("wr_c2_addr", addr_a, 18'h20);
      chk("wr_c2_we", we_a, 0);
      step();
      chk("wr_c3_addr", addr_a, 18'h21);
      chk("wr_c3_dq", dq_a, 16'hDEAD);
      chk("wr_c3_we", we_a, 0);
      step();
      chk("wr_c4_addr", addr_a, 18'h21);
      chk("wr_c4_we", we_a, 0);
      step();
      chk("wr_c5_ready", ifa.ready, 1);
      chk("wr_c5_strobes", {we_a, ce_a}, 2'b11);
      chk("wr_c5_addr", addr_a, 0);
      chk("wr_mem_lo", mem_a[8'h20], 16'hBEEF);
      chk("wr_mem_hi", mem_a[8'h21], 16'hDEAD);
      step();

      // read back 0x40
      ifa.rd_en = 1; ifa.addr = 32'h40;
      pulses = 0; we_low = 0;
      step(); ifa.rd_en = 0;
      chk("rd_c1_addr", addr_a, 18'h20);
      chk("rd_c1_oe", oe_a, 0);
      for (int c = 1; c <= 4; c++) begin
         pulses += int'(ifa.rd_valid);
         we_low += int'(!we_a);
         if (c < 4) step();
      end
      step();
      chk("rd_c5_valid", ifa.rd_valid, 1);
      chk("rd_c5_data", ifa.rd_data, 32'hDEADBEEF);
      chk("rd_c5_ready", ifa.ready, 1);
      pulses += int'(ifa.rd_valid);
      step();
      pulses += int'(ifa.rd_valid);
      chk("rd_valid_pulses", pulses, 1);
      chk("rd_we_never_low", we_low, 0);

      // masked write byte_en=0x6
      ifa.wr_en = 1; ifa.addr = 32'h40; ifa.wr_data = 32'h11223344; ifa.byte_en = 4'h6;
      step(); ifa.wr_en = 0;
      chk("mask_b0_lanes", {ub_a, lb_a}, 2'b01);
      step(); step();
      chk("mask_b1_lanes", {ub_a, lb_a}, 2'b10);
      step(); step(); step();
      ifa.rd_en = 1;
      step(); ifa.rd_en = 0;
      step(); step(); step(); step();
      chk("mask_readback", ifa.rd_data, 32'hDE2233EF);
      step();

      // simultaneous wr_en and rd_en: write wins
      ifa.wr_en = 1; ifa.rd_en = 1; ifa.addr = 32'h80; ifa.wr_data = 32'hCAFEF00D; ifa.byte_en = 4'hF;
      pulses = 0;
      step(); ifa.wr_en = 0; ifa.rd_en = 0;
      chk("both_we", we_a, 0);
      chk("both_oe", oe_a, 1);
      for (int c = 0; c < 6; c++) begin
         pulses += int'(ifa.rd_valid);
         step();
      end
      chk("both_no_valid", pulses, 0);
      chk("both_mem_lo", mem_a[8'h40], 16'hF00D);
      chk("both_mem_hi", mem_a[8'h41], 16'hCAFE);

      // reset in 2nd cycle of a read
      ifa.rd_en = 1; ifa.addr = 32'h80;
      step(); ifa.rd_en = 0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_ce", ce_a, 1);
      chk("abort_valid", ifa.rd_valid, 0);
      pulses = 0;
      for (int c = 0; c < 5; c++) begin
         pulses += int'(ifa.rd_valid);
         step();
      end
      chk("abort_no_valid", pulses, 0);
      ifa.rd_en = 1; ifa.addr = 32'h80;
      step(); ifa.rd_en = 0;
      step(); step(); step(); step();
      chk("after_abort_valid", ifa.rd_valid, 1);
      chk("after_abort_data", ifa.rd_data, 32'hCAFEF00D);
      step();

      // 64-bit, zero wait: write then read @0x18
      ifb.wr_en = 1; ifb.addr = 32'h18; ifb.wr_data = 64'h0123456789ABCDEF; ifb.byte_en = 8'hFF;
      step(); ifb.wr_en = 0;
      step(); step(); step(); step();
      chk("w64_ready", ifb.ready, 1);
      step();
      ifb.rd_en = 1;
      step(); ifb.rd_en = 0;
      chk("r64_c1_addr", addr_b, 18'h0C);
      step();
      chk("r64_c2_addr", addr_b, 18'h0D);
      step();
      chk("r64_c3_addr", addr_b, 18'h0E);
      step();
      chk("r64_c4_addr", addr_b, 18'h0F);
      chk("r64_c4_ready", ifb.ready, 0);
      step();
      chk("r64_c5_valid", ifb.rd_valid, 1);
      chk("r64_c5_ready", ifb.ready, 1);
      chk("r64_data", ifb.rd_data, 64'h0123456789ABCDEF);
      step();
      chk("r64_c6_valid", ifb.rd_valid, 0);
      chk("r64_a_untouched", ifa.rd_data, 32'hCAFEF00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
